// File: rtl/door_pkg.sv
// Shared definitions for the revolving-door arbiter: state codes, door
// directions and the HEX debug-display segment patterns.
package door_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GRANT_IN  = 3'd1,
        ST_GRANT_OUT = 3'd2,
        ST_ALARM     = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_CLEAR     = 3'd5
    } state_e;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

    // Active-low seven-segment patterns {g,f,e,d,c,b,a} for the state digit.
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] state_to_seg(input logic [2:0] code);
        logic [6:0] seg;
        case (code)
            3'd0:    seg = SEG_0;
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/door_access_arbiter_if.sv
// Sensor inputs and door drive/indicator outputs of the door arbiter.
interface door_access_arbiter_if #(
    parameter int OCC_W = 8
);
    logic             req_in;
    logic             req_out;
    logic             metal;
    logic             pass_done;
    logic             guard_clr;
    logic             grant_in;
    logic             grant_out;
    logic             green;
    logic             red;
    logic             buzzer;
    logic             full;
    logic [OCC_W-1:0] occupancy;
    logic [2:0]       state_code;

    // Board side: drives the sensors and observes the door.
    modport master (
        output req_in, req_out, metal, pass_done, guard_clr,
        input  grant_in, grant_out, green, red, buzzer, full, occupancy, state_code
    );

    // Arbiter side.
    modport slave (
        input  req_in, req_out, metal, pass_done, guard_clr,
        output grant_in, grant_out, green, red, buzzer, full, occupancy, state_code
    );
endinterface

// File: rtl/door_occ_counter.sv
// Saturating up/down head counter; full is decoded straight from the count register.
module door_occ_counter #(
    parameter int W   = 8,
    parameter int MAX = 200
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         full
);
    localparam logic [W-1:0] TOP   = '1;
    localparam logic [W-1:0] LIMIT = W'(MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && count != TOP) begin
            count <= count + W'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign full = (count >= LIMIT);

endmodule

// File: rtl/door_access_arbiter.sv
// Revolving-door arbiter: round-robin entry/exit grants, metal alarm and lockout,
// grant timeout and occupancy tracking. All door/lamp outputs are registered.
module door_access_arbiter
    import door_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ALARM_CYCLES   = 8,
    parameter int MAX_OCC        = 200,
    parameter int OCC_W          = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    door_access_arbiter_if.slave bus
);
    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_GRANT_IN  = ST_GRANT_IN;
    localparam logic [2:0] S_GRANT_OUT = ST_GRANT_OUT;
    localparam logic [2:0] S_ALARM     = ST_ALARM;
    localparam logic [2:0] S_LOCKED    = ST_LOCKED;
    localparam logic [2:0] S_CLEAR     = ST_CLEAR;

    // One timer serves both the grant timeout and the buzzer period.
    localparam int TMR_MAX = (TIMEOUT_CYCLES > ALARM_CYCLES) ? TIMEOUT_CYCLES : ALARM_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] ALM_LAST = TMR_W'(ALARM_CYCLES - 1);

    logic [2:0]       state, state_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic             last_grant, last_grant_nx;
    logic             occ_inc, occ_dec;
    logic             entry_ok, exit_ok, pick_in;
    logic             full_w;
    logic [OCC_W-1:0] occ_w;
    logic             grant_in_q, grant_out_q, green_q, red_q, buzzer_q;

    door_occ_counter #(
        .W   (OCC_W),
        .MAX (MAX_OCC)
    ) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (occ_inc),
        .dec   (occ_dec),
        .count (occ_w),
        .full  (full_w)
    );

    assign entry_ok = bus.req_in && !full_w;
    assign exit_ok  = bus.req_out;
    assign pick_in  = entry_ok && (!exit_ok || last_grant == DIR_OUT);

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx      = state;
        timer_nx      = timer + TMR_W'(1);
        last_grant_nx = last_grant;
        occ_inc       = 1'b0;
        occ_dec       = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_in)      state_nx = bus.metal ? S_ALARM : S_GRANT_IN;
                else if (exit_ok) state_nx = S_GRANT_OUT;
            end
            S_GRANT_IN, S_GRANT_OUT: begin
                if (bus.pass_done || timer == TMO_LAST) begin
                    state_nx      = S_CLEAR;
                    last_grant_nx = (state == S_GRANT_IN) ? DIR_IN : DIR_OUT;
                    occ_inc       = bus.pass_done && (state == S_GRANT_IN);
                    occ_dec       = bus.pass_done && (state == S_GRANT_OUT);
                end
            end
            S_ALARM: begin
                if (timer == ALM_LAST) state_nx = S_LOCKED;
            end
            S_LOCKED: begin
                if (bus.guard_clr) begin
                    state_nx      = S_CLEAR;
                    last_grant_nx = DIR_IN;
                end
            end
            S_CLEAR: begin
                // Hold until both sensors are empty so a lingering person is not served twice.
                if (!bus.req_in && !bus.req_out) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (state_nx != state) timer_nx = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            timer       <= '0;
            last_grant  <= DIR_OUT;
            grant_in_q  <= 1'b0;
            grant_out_q <= 1'b0;
            green_q     <= 1'b0;
            red_q       <= 1'b0;
            buzzer_q    <= 1'b0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            last_grant  <= last_grant_nx;
            grant_in_q  <= (state_nx == S_GRANT_IN);
            grant_out_q <= (state_nx == S_GRANT_OUT);
            green_q     <= (state_nx == S_GRANT_IN) || (state_nx == S_GRANT_OUT);
            red_q       <= (state_nx == S_ALARM) || (state_nx == S_LOCKED);
            buzzer_q    <= (state_nx == S_ALARM);
        end
    end

    assign bus.grant_in   = grant_in_q;
    assign bus.grant_out  = grant_out_q;
    assign bus.green      = green_q;
    assign bus.red        = red_q;
    assign bus.buzzer     = buzzer_q;
    assign bus.full       = full_w;
    assign bus.occupancy  = occ_w;
    assign bus.state_code = state;

endmodule
